// File: rtl/klein_key_sched_if.sv
// Key-in / round-key-out handshake bundle for the KLEIN-80 key schedule.
// master drives the key and accepts round keys; slave is the schedule block.
interface klein_key_sched_if;
    logic [79:0] key;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] rk_data;
    logic [4:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready;
    logic        done;

    modport master (
        output key, key_valid, rk_ready,
        input  key_ready, rk_data, rk_idx, rk_valid, done
    );

    modport slave (
        input  key, key_valid, rk_ready,
        output key_ready, rk_data, rk_idx, rk_valid, done
    );
endinterface

// File: rtl/klein_key_sched.sv
// KLEIN-80 key schedule: expands a master key into NR+1 round keys, one step
// per cycle, then streams them out last-to-first for a decryption datapath.
module klein_key_sched #(
    parameter int unsigned NR = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    klein_key_sched_if.slave   bus
);

    localparam int unsigned KEY_W = 80;
    localparam int unsigned RK_W  = 64;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SLOTS = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'h9;
            4'h4: y = 4'h1;  4'h5: y = 4'hF;  4'h6: y = 4'hB;  4'h7: y = 4'h0;
            4'h8: y = 4'hC;  4'h9: y = 4'h3;  4'hA: y = 4'h2;  4'hB: y = 4'h6;
            4'hC: y = 4'h8;  4'hD: y = 4'hE;  4'hE: y = 4'hD;  default: y = 4'h5;
        endcase
        return y;
    endfunction

    // One key-schedule step: rotate halves, Feistel swap, round constant, S-box.
    function automatic logic [KEY_W-1:0] ks_step(input logic [KEY_W-1:0] s,
                                                 input logic [CNT_W-1:0] i);
        logic [39:0] ar, br, na, nb;
        ar = {s[71:40], s[79:72]};
        br = {s[31:0],  s[39:32]};
        na = br;
        nb = ar ^ br;
        na[23:16] = na[23:16] ^ i;
        for (int n = 0; n < 4; n++) begin
            nb[16+4*n +: 4] = sbox(nb[16+4*n +: 4]);
        end
        return {na, nb};
    endfunction

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [KEY_W-1:0] sk, sk_nxt;
    logic             key_ready_q, key_ready_nxt;
    logic             rk_valid_q, rk_valid_nxt;
    logic             done_q, done_nxt;
    logic [IDX_W-1:0] rk_idx_q, rk_idx_nxt;
    logic [RK_W-1:0]  rk_data_q, rk_data_nxt;

    logic             slot_we;
    logic [IDX_W-1:0] slot_wa;
    logic [RK_W-1:0]  slot_wd;
    logic [RK_W-1:0]  slot [SLOTS];
    logic [RK_W-1:0]  slot_rd;
    logic [KEY_W-1:0] ks_out;

    assign ks_out  = ks_step(sk, cnt);
    assign slot_rd = slot[rk_idx_q - IDX_W'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sk          <= '0;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            rk_idx_q    <= '0;
            rk_data_q   <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sk          <= sk_nxt;
            key_ready_q <= key_ready_nxt;
            rk_valid_q  <= rk_valid_nxt;
            done_q      <= done_nxt;
            rk_idx_q    <= rk_idx_nxt;
            rk_data_q   <= rk_data_nxt;
        end
    end

    // Round-key storage holds no secrets on the outputs unless rk_valid is set.
    always_ff @(posedge clk) begin
        if (slot_we) begin
            slot[slot_wa] <= slot_wd;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        sk_nxt        = sk;
        key_ready_nxt = key_ready_q;
        rk_valid_nxt  = rk_valid_q;
        done_nxt      = 1'b0;
        rk_idx_nxt    = rk_idx_q;
        rk_data_nxt   = rk_data_q;
        slot_we       = 1'b0;
        slot_wa       = '0;
        slot_wd       = '0;

        case (state)
            IDLE: begin
                if (bus.key_valid && key_ready_q) begin
                    state_nxt     = EXPAND;
                    sk_nxt        = bus.key;
                    cnt_nxt       = CNT_W'(1);
                    key_ready_nxt = 1'b0;
                    slot_we       = 1'b1;
                    slot_wa       = IDX_W'(1);
                    slot_wd       = bus.key[79:16];
                end
            end

            EXPAND: begin
                sk_nxt  = ks_out;
                cnt_nxt = cnt + CNT_W'(1);
                slot_we = 1'b1;
                slot_wa = IDX_W'(cnt + CNT_W'(1));
                slot_wd = ks_out[79:16];
                // Last step feeds the first streamed key straight from the datapath.
                if (cnt == CNT_W'(NR)) begin
                    state_nxt    = STREAM;
                    cnt_nxt      = '0;
                    rk_valid_nxt = 1'b1;
                    rk_idx_nxt   = IDX_W'(NR + 1);
                    rk_data_nxt  = ks_out[79:16];
                end
            end

            STREAM: begin
                if (bus.rk_ready) begin
                    if (rk_idx_q == IDX_W'(1)) begin
                        state_nxt     = IDLE;
                        rk_valid_nxt  = 1'b0;
                        done_nxt      = 1'b1;
                        key_ready_nxt = 1'b1;
                        rk_idx_nxt    = '0;
                        rk_data_nxt   = '0;
                    end else begin
                        rk_idx_nxt  = rk_idx_q - IDX_W'(1);
                        rk_data_nxt = slot_rd;
                    end
                end
            end

            default: begin
                state_nxt     = IDLE;
                key_ready_nxt = 1'b1;
                rk_valid_nxt  = 1'b0;
                rk_idx_nxt    = '0;
                rk_data_nxt   = '0;
            end
        endcase
    end

    assign bus.key_ready = key_ready_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.done      = done_q;
    assign bus.rk_idx    = rk_idx_q;
    assign bus.rk_data   = rk_data_q;

endmodule
